// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, immediate formats
// and the ID/EX pipeline register layout.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // ID/EX register contents; widths fixed at 32 since only RV32 is supported
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        illegal;
  } idex_t;

  // Immediate layout implied by the major opcode
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // Register/immediate arithmetic op; alt selects SUB for funct3=000, SRA for 101
  function automatic alu_op_e alu_op_of(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle between the decode stage and its surroundings: IF/ID
// register, register-file read/write ports, EX redirect and ID/EX payload.
// master = pipeline surroundings, slave = the decode stage.
interface id_stage_if #(parameter int XLEN = 32);

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            stall_if;
  logic            flush;

  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  logic            wb_we;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_rd_data;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1_addr;
  logic [4:0]      ex_rs2_addr;
  logic [4:0]      ex_rd_addr;
  logic [2:0]      ex_funct3;
  logic [3:0]      ex_alu_op;
  logic            ex_alu_src_imm;
  logic            ex_alu_src_pc;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_jalr;
  logic            ex_illegal;

  modport master (
    output if_valid, if_pc, if_instr, flush, rs1_data, rs2_data,
           wb_we, wb_rd_addr, wb_rd_data,
    input  stall_if, rs1_addr, rs2_addr,
           ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct3, ex_alu_op,
           ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instr, flush, rs1_data, rs2_data,
           wb_we, wb_rd_addr, wb_rd_data,
    output stall_if, rs1_addr, rs2_addr,
           ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct3, ex_alu_op,
           ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_illegal
  );

endinterface

// File: rtl/id_stage_imm_gen.sv
// Immediate generator: extracts and sign-extends the I/S/B/U/J immediate
// selected by the instruction's opcode. Non-immediate formats yield zero.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // Reassemble the scattered immediate bits for the decoded format
  always_comb begin
    imm = '0;
    case (imm_fmt_of(instr[6:0]))
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: control decode, operand read with writeback bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input logic     clk,
  input logic     rst,
  id_stage_if.slave bus
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic [31:0] imm;

  alu_op_e dec_alu_op;
  logic    dec_alu_src_imm;
  logic    dec_alu_src_pc;
  logic    dec_mem_read;
  logic    dec_mem_write;
  logic    dec_reg_write;
  logic    dec_branch;
  logic    dec_jump;
  logic    dec_jalr;
  logic    dec_illegal;
  logic    rs1_used;
  logic    rs2_used;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            hazard;

  idex_t ex_d;
  idex_t ex_q;

  assign opcode       = bus.if_instr[6:0];
  assign funct3       = bus.if_instr[14:12];
  assign rd_addr      = bus.if_instr[11:7];
  assign bus.rs1_addr = bus.if_instr[19:15];
  assign bus.rs2_addr = bus.if_instr[24:20];

  imm_gen u_imm_gen (
    .instr (bus.if_instr),
    .imm   (imm)
  );

  // Control decode; unknown opcodes are flagged illegal with no side effects
  always_comb begin
    dec_alu_op      = ALU_ADD;
    dec_alu_src_imm = 1'b0;
    dec_alu_src_pc  = 1'b0;
    dec_mem_read    = 1'b0;
    dec_mem_write   = 1'b0;
    dec_reg_write   = 1'b0;
    dec_branch      = 1'b0;
    dec_jump        = 1'b0;
    dec_jalr        = 1'b0;
    dec_illegal     = 1'b0;
    rs1_used        = 1'b1;
    rs2_used        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_alu_op      = ALU_PASS_B;
        dec_alu_src_imm = 1'b1;
        dec_reg_write   = 1'b1;
        rs1_used        = 1'b0;
      end
      OPC_AUIPC: begin
        dec_alu_src_imm = 1'b1;
        dec_alu_src_pc  = 1'b1;
        dec_reg_write   = 1'b1;
        rs1_used        = 1'b0;
      end
      OPC_JAL: begin
        dec_alu_src_imm = 1'b1;
        dec_alu_src_pc  = 1'b1;
        dec_reg_write   = 1'b1;
        dec_jump        = 1'b1;
        rs1_used        = 1'b0;
      end
      OPC_JALR: begin
        dec_alu_src_imm = 1'b1;
        dec_reg_write   = 1'b1;
        dec_jump        = 1'b1;
        dec_jalr        = 1'b1;
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        rs2_used   = 1'b1;
        case (funct3[2:1])
          2'b10:   dec_alu_op = ALU_SLT;
          2'b11:   dec_alu_op = ALU_SLTU;
          default: dec_alu_op = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        dec_alu_src_imm = 1'b1;
        dec_mem_read    = 1'b1;
        dec_reg_write   = 1'b1;
      end
      OPC_STORE: begin
        dec_alu_src_imm = 1'b1;
        dec_mem_write   = 1'b1;
        rs2_used        = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_alu_op      = alu_op_of(funct3, (funct3 == 3'b101) && bus.if_instr[30]);
        dec_alu_src_imm = 1'b1;
        dec_reg_write   = 1'b1;
      end
      OPC_OP: begin
        dec_alu_op    = alu_op_of(funct3, bus.if_instr[30]);
        dec_reg_write = 1'b1;
        rs2_used      = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
    if (rd_addr == 5'd0) begin
      dec_reg_write = 1'b0;
    end
  end

  // Operand select: x0 is always zero, otherwise take a same-cycle writeback
  always_comb begin
    rs1_val = bus.rs1_data;
    rs2_val = bus.rs2_data;
    if (bus.rs1_addr == 5'd0) begin
      rs1_val = '0;
    end else if (WB_BYPASS && bus.wb_we && (bus.wb_rd_addr == bus.rs1_addr)) begin
      rs1_val = bus.wb_rd_data;
    end
    if (bus.rs2_addr == 5'd0) begin
      rs2_val = '0;
    end else if (WB_BYPASS && bus.wb_we && (bus.wb_rd_addr == bus.rs2_addr)) begin
      rs2_val = bus.wb_rd_data;
    end
  end

  // Load-use hazard against the load currently sitting in EX
  always_comb begin
    hazard = bus.if_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != 5'd0) &&
             ((rs1_used && (bus.rs1_addr == ex_q.rd_addr)) ||
              (rs2_used && (bus.rs2_addr == ex_q.rd_addr)));
    bus.stall_if = hazard && !bus.flush && rst;
  end

  // Next ID/EX contents: load decode results, or insert a bubble on kill
  always_comb begin
    ex_d.valid       = bus.if_valid;
    ex_d.pc          = bus.if_pc;
    ex_d.rs1_val     = rs1_val;
    ex_d.rs2_val     = rs2_val;
    ex_d.imm         = imm;
    ex_d.rs1_addr    = bus.rs1_addr;
    ex_d.rs2_addr    = bus.rs2_addr;
    ex_d.rd_addr     = rd_addr;
    ex_d.funct3      = funct3;
    ex_d.alu_op      = dec_alu_op;
    ex_d.alu_src_imm = dec_alu_src_imm;
    ex_d.alu_src_pc  = dec_alu_src_pc;
    ex_d.mem_read    = dec_mem_read;
    ex_d.mem_write   = dec_mem_write;
    ex_d.reg_write   = dec_reg_write;
    ex_d.branch      = dec_branch;
    ex_d.jump        = dec_jump;
    ex_d.jalr        = dec_jalr;
    ex_d.illegal     = dec_illegal;
    if (bus.flush || hazard || !bus.if_valid) begin
      ex_d.valid     = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.branch    = 1'b0;
      ex_d.jump      = 1'b0;
      ex_d.jalr      = 1'b0;
      ex_d.illegal   = 1'b0;
    end
  end

  // ID/EX register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_pc          = ex_q.pc;
  assign bus.ex_rs1_val     = ex_q.rs1_val;
  assign bus.ex_rs2_val     = ex_q.rs2_val;
  assign bus.ex_imm         = ex_q.imm;
  assign bus.ex_rs1_addr    = ex_q.rs1_addr;
  assign bus.ex_rs2_addr    = ex_q.rs2_addr;
  assign bus.ex_rd_addr     = ex_q.rd_addr;
  assign bus.ex_funct3      = ex_q.funct3;
  assign bus.ex_alu_op      = ex_q.alu_op;
  assign bus.ex_alu_src_imm = ex_q.alu_src_imm;
  assign bus.ex_alu_src_pc  = ex_q.alu_src_pc;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_branch      = ex_q.branch;
  assign bus.ex_jump        = ex_q.jump;
  assign bus.ex_jalr        = ex_q.jalr;
  assign bus.ex_illegal     = ex_q.illegal;

endmodule
